ksa_bist_sequencer: RTL
=======================

// Module: ksa_bist_sequencer
// PURPOSE
//   On-chip built-in self-test for the Kogge-Stone adder.
//   - Generates every {b,a} operand pair and drives it onto the adder operand bus.
//   - Captures the adder sum after a fixed latency and compares it with a behavioural a+b.
//   - Reports pass/fail, an error count and the first failing vector.
//   - Sits beside the adder inside the tile wrapper.
// PARAMETERS
//   WIDTH      4  operand width; stim is 2*WIDTH bits, 2^(2*WIDTH) vectors
//   LATENCY    0  adder cycles from stim change to valid dut_sum (0 = combinational)
//   ERR_CNT_W  8  width of saturating error counter
// PORTS
//   clk             in   1          system clock, all state on rising edge
//   rst             in   1          synchronous active-high reset
//   start           in   1          begin/restart test; sampled in IDLE and DONE only
//   stim            out  2*WIDTH    operand bus {b,a}; b=stim[2W-1:W], a=stim[W-1:0]
//   dut_sum         in   2*WIDTH    adder result
//   busy            out  1          high while test running
//   done            out  1          high (level) while in DONE
//   pass            out  1          done & (err_count==0); 0 otherwise
//   err_count       out  ERR_CNT_W  mismatches this run, saturating
//   first_fail_vec  out  2*WIDTH    stim of first mismatch; 0 if none
// BEHAVIOUR
//   Reset: state=IDLE; stim, busy, done, pass, err_count, first_fail_vec all 0; vec, wcnt = 0.
//     - Takes priority over everything.
//     - Asserted mid-run, it aborts the run; outputs read 0 on the next cycle.
//   FSM states: IDLE, RUN, DONE.
//   IDLE
//     - stim=0.
//     - start=1 -> RUN; vec=0, wcnt=0, err_count=0, first_fail_vec=0.
//   RUN
//     - busy=1, stim=vec; vec and stim are held while wcnt counts 0..LATENCY.
//     - When wcnt==LATENCY, compare dut_sum with exp = zero_ext(a)+zero_ext(b), width 2*WIDTH.
//       - Mismatch: err_count+1, saturating at all-ones.
//       - Mismatch and err_count==0 beforehand: first_fail_vec=vec.
//       - Then: vec==all-ones -> DONE; else vec+1, wcnt=0.
//     - start is ignored.
//     - Run length: 2^(2*WIDTH)*(LATENCY+1) cycles in RUN.
//   DONE
//     - busy=0, done=1, stim=0.
//     - err_count and first_fail_vec are held; pass=(err_count==0).
//     - start=1 -> RUN with the same clearing as from IDLE; done drops next cycle.
//   Arithmetic: the expected sum includes the carry-out bit (WIDTH+1 significant bits);
//     upper bits must be 0.
//   Simultaneous rst and start: rst wins.
//   The vec wrap from all-ones is never taken; the transition is to DONE instead.
// TESTING
//   1 Ideal comb adder model, LATENCY=0, pulse start
//     -> busy 256 cycles, done=1, pass=1, err_count=0, first_fail_vec=0.
//   2 Model with sum bit0 stuck 0, LATENCY=0
//     -> err_count=128, first_fail_vec=8'h01, pass=0.
//   3 One-register adder model, LATENCY=1
//     -> 512 RUN cycles, pass=1; stim stable for 2 cycles per vector.
//   4 rst=1 when vec=8'h40
//     -> next cycle all outputs 0, IDLE; new start restarts from vec 0 and passes.
//   5 ERR_CNT_W=4, dut_sum tied 8'hFF
//     -> err_count saturates at 4'hF, first_fail_vec=8'h00, pass=0.
//   6 start pulsed mid-RUN -> ignored (vec continues).
//     start in DONE after a failing run -> err cleared, rerun with ideal model gives pass=1.

Source files
------------

// File: rtl/ksa_bist_sequencer.sv
// Purpose : built-in self-test for the Kogge-Stone adder. Sweeps every {b,a} operand pair,
//           checks each adder sum against a behavioural a+b, reports pass/fail and the first bad vector.
// Latency : 2^(2*WIDTH)*(LATENCY+1) cycles in RUN per test; each vector is held LATENCY+1 cycles.
// Backpr. : none. The adder is assumed to produce a sum exactly LATENCY cycles after stim changes.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset (wins over start)
//   start           begin/restart a test; honoured only in IDLE and DONE
//   stim            operand bus {b,a} driven to the adder; 0 outside RUN
//   dut_sum         adder result, 2*WIDTH bits, upper bits above the carry must be 0
//   busy / done     test running / test finished (level while in DONE)
//   pass            done and no mismatches
//   err_count       saturating mismatch count for the current run
//   first_fail_vec  stim of the first mismatch, 0 if none
module ksa_bist_sequencer #(
  parameter int WIDTH     = 4,
  parameter int LATENCY   = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [2*WIDTH-1:0]   stim,
  input  logic [2*WIDTH-1:0]   dut_sum,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [2*WIDTH-1:0]   first_fail_vec
);

  localparam int SW     = 2 * WIDTH;
  // wcnt needs at least one bit even for a combinational adder
  localparam int WCNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [WCNT_W-1:0]    WCNT_LAST = WCNT_W'(LATENCY);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SW-1:0]     vec;
  logic [WCNT_W-1:0] wcnt;
  logic [SW-1:0]     exp_sum;
  logic              sample;
  logic              mismatch;
  logic              last_vec;
  logic              launch;

  // Both operands zero-extended to the full bus so the carry-out lands in bit WIDTH
  // and every bit above it is expected to be 0.
  assign exp_sum  = {{WIDTH{1'b0}}, vec[WIDTH-1:0]} + {{WIDTH{1'b0}}, vec[SW-1:WIDTH]};
  assign sample   = (state == S_RUN) && (wcnt == WCNT_LAST);
  assign mismatch = sample && (dut_sum != exp_sum);
  assign last_vec = &vec;
  assign launch   = start && ((state == S_IDLE) || (state == S_DONE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (sample && last_vec) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    stim = '0;
    case (state)
      S_RUN: begin
        busy = 1'b1;
        stim = vec;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    pass = done && (err_count == '0);
  end

  // Vector walker, settle counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      vec            <= '0;
      wcnt           <= '0;
      err_count      <= '0;
      first_fail_vec <= '0;
    end else if (launch) begin
      vec            <= '0;
      wcnt           <= '0;
      err_count      <= '0;
      first_fail_vec <= '0;
    end else if (state == S_RUN) begin
      if (sample) begin
        if (mismatch) begin
          if (err_count != ERR_MAX) err_count <= err_count + ERR_CNT_W'(1);
          if (err_count == '0)      first_fail_vec <= vec;
        end
        // The all-ones vector ends the run instead of wrapping to 0.
        if (!last_vec) begin
          vec  <= vec + SW'(1);
          wcnt <= '0;
        end
      end else begin
        wcnt <= wcnt + WCNT_W'(1);
      end
    end
  end

endmodule
